// File: rtl/gate_activation.sv
// gate_activation: captures a pre-activation vector and applies a piecewise-linear sigmoid/tanh, one element per cycle
module gate_activation #(
  parameter int HIDDEN_SZ = 16,
  parameter int QN = 6,
  parameter int QM = 11,
  parameter int FUNC = 0,
  localparam int BITWIDTH = QN + QM + 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LAYER_BITWIDTH-1:0] gateOutput,
  input  logic                      dataReady_gate,
  output logic                      busy,
  output logic                      overrun,
  output logic                      dataReady_act,
  output logic [LAYER_BITWIDTH-1:0] actOutput
);
  localparam int B = BITWIDTH;
  localparam int IW = HIDDEN_SZ > 1 ? $clog2(HIDDEN_SZ) : 1;
  localparam logic [B-1:0] MAXP = {1'b0, {(B-1){1'b1}}};
  localparam logic [B-1:0] MINN = {1'b1, {(B-1){1'b0}}};
  localparam logic [B-1:0] ONE = B'(1 << QM);
  localparam logic [B-1:0] T2 = B'((19 << QM) >> 3);
  localparam logic [B-1:0] T3 = B'(5 << QM);
  localparam logic [B-1:0] C1 = B'(1 << (QM - 1));
  localparam logic [B-1:0] C2 = B'((5 << QM) >> 3);
  localparam logic [B-1:0] C3 = B'((27 << QM) >> 5);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, next;
  logic [LAYER_BITWIDTH-1:0] in_buf, res;
  logic [IW-1:0] idx, s1_idx;
  logic s1_valid, s1_sign;
  logic [B-1:0] s1_mag, x, z, mag, s, sp, y;
  logic [B:0] x2;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // next-state: a job walks RUN for every element, then one drain and one publish cycle
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = dataReady_gate ? RUN : IDLE;
      RUN:   next = idx == IW'(HIDDEN_SZ - 1) ? DRAIN : RUN;
      DRAIN: next = DONE;
      DONE:  next = IDLE;
    endcase
  end
  // stage 1 combinational: pick element, double and saturate for tanh, split into sign and magnitude
  always_comb begin
    x = in_buf[idx*B +: B];
    x2 = {x, 1'b0};
    z = FUNC != 0 ? (x2[B] != x2[B-1] ? (x2[B] ? MINN : MAXP) : x2[B-1:0]) : x;
    mag = z[B-1] ? (z == MINN ? MAXP : -z) : z;
  end
  // stage 2 combinational: three-segment sigmoid on the magnitude, mirror for negatives, rescale for tanh
  always_comb begin
    s = s1_mag < ONE ? (s1_mag >> 2) + C1 :
        s1_mag < T2  ? (s1_mag >> 3) + C2 :
        s1_mag < T3  ? (s1_mag >> 5) + C3 : ONE;
    sp = s1_sign ? ONE - s : s;
    y = FUNC != 0 ? (sp << 1) - ONE : sp;
  end
  // datapath: input capture, pipeline registers, result buffer and atomic publish
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      in_buf <= '0;
      res <= '0;
      actOutput <= '0;
      idx <= '0;
      s1_idx <= '0;
      s1_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag <= '0;
      overrun <= 1'b0;
      dataReady_act <= 1'b0;
    end else begin
      overrun <= dataReady_gate && state != IDLE;
      dataReady_act <= state == DONE;
      s1_valid <= state == RUN;
      if (state == IDLE && dataReady_gate) begin
        in_buf <= gateOutput;
        idx <= '0;
      end
      if (state == RUN) begin
        s1_sign <= z[B-1];
        s1_mag <= mag;
        s1_idx <= idx;
        idx <= idx + 1'b1;
      end
      if (s1_valid) res[s1_idx*B +: B] <= y;
      if (state == DONE) actOutput <= res;
    end
endmodule
